// File: rtl/mem_ahb_master.sv
// ============================================================================
//  Module      : mem_ahb_master
//  Description : MEM-stage AHB-Lite data-memory master for the pipelined MIPS
//                core. Single transfers, pipeline stall, load extension.
//                Optional misaligned-access rejection: define ALIGN_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ahb_master #(
  parameter int          ADDR_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start_M,
  input  logic [1:0]        i_htrans_M,
  input  logic              MemWrite_M,
  input  logic              LOAD_BYTE,
  input  logic              LOAD_HW,
  input  logic              LOAD_WORD,
  input  logic              LOAD_BYTE_UNSIGNED,
  input  logic              LOAD_HW_UNSIGNED,
  input  logic              STORE_BYTE,
  input  logic              STORE_HW,
  input  logic              STORE_WORD,
  input  logic [ADDR_W-1:0] ALUOut_M,
  input  logic [31:0]       WriteData_M,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              mem_stall,
  output logic [31:0]       ReadData_M,
  output logic              rd_valid,
  output logic              bus_error,
  output logic              addr_error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_haddr;
  logic [1:0]        r_htrans;
  logic              r_hwrite;
  logic [2:0]        r_hsize;
  logic [31:0]       r_hwdata;
  logic              r_unsigned;

  logic              w_req;
  logic              w_is_store;
  logic              w_is_load;
  logic              w_valid;
  logic              w_write;
  logic [2:0]        w_size;
  logic              w_unsigned;
  logic              w_go;
  logic              w_reject;
  logic [ADDR_W-1:0] w_addr_out;
  logic [31:0]       w_wdata_lanes;
  logic              w_in_idle;
  logic              w_in_addr;
  logic              w_in_data;
  logic              w_done;
  logic [7:0]        w_rbyte;
  logic [15:0]       w_rhalf;
  logic [31:0]       w_load_ext;

  assign w_req      = i_start_M & (i_htrans_M == TR_NONSEQ);
  assign w_is_store = STORE_BYTE | STORE_HW | STORE_WORD;
  assign w_is_load  = LOAD_BYTE | LOAD_HW | LOAD_WORD | LOAD_BYTE_UNSIGNED | LOAD_HW_UNSIGNED;
  assign w_valid    = w_is_store | w_is_load;
  // Store flags dominate when decode asserts both groups.
  assign w_write    = w_is_store | (MemWrite_M & ~w_is_load);
  assign w_unsigned = LOAD_BYTE_UNSIGNED | LOAD_HW_UNSIGNED;

  always_comb begin
    w_size = SZ_WORD;
    if (w_is_store) begin
      if (STORE_BYTE)    w_size = SZ_BYTE;
      else if (STORE_HW) w_size = SZ_HALF;
    end else begin
      if (LOAD_BYTE | LOAD_BYTE_UNSIGNED)  w_size = SZ_BYTE;
      else if (LOAD_HW | LOAD_HW_UNSIGNED) w_size = SZ_HALF;
    end
  end

`ifdef ALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign = ((w_size == SZ_HALF) & ALUOut_M[0]) |
                      ((w_size == SZ_WORD) & (|ALUOut_M[1:0]));
  assign w_reject   = w_req & w_valid & w_misalign;
  assign w_go       = w_req & w_valid & ~w_misalign;
  assign w_addr_out = ALUOut_M;
`else
  assign w_reject   = 1'b0;
  assign w_go       = w_req & w_valid;
  // Misaligned half/word accesses are silently rounded down to their natural boundary.
  always_comb begin
    w_addr_out = ALUOut_M;
    if (w_size == SZ_HALF)      w_addr_out[0]   = 1'b0;
    else if (w_size == SZ_WORD) w_addr_out[1:0] = 2'b00;
  end
`endif

  always_comb begin
    case (w_size)
      SZ_BYTE: w_wdata_lanes = {4{WriteData_M[7:0]}};
      SZ_HALF: w_wdata_lanes = {2{WriteData_M[15:0]}};
      default: w_wdata_lanes = WriteData_M;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_haddr    <= '0;
      r_htrans   <= TR_IDLE;
      r_hwrite   <= 1'b0;
      r_hsize    <= SZ_BYTE;
      r_hwdata   <= '0;
      r_unsigned <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state    <= S_ADDR;
            r_htrans   <= TR_NONSEQ;
            r_haddr    <= w_addr_out;
            r_hwrite   <= w_write;
            r_hsize    <= w_size;
            r_unsigned <= w_unsigned;
            if (w_write) r_hwdata <= w_wdata_lanes;
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            r_state  <= S_DATA;
            r_htrans <= TR_IDLE;
          end
        end
        S_DATA: begin
          if (HREADY) r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_htrans <= TR_IDLE;
        end
      endcase
    end
  end

  assign w_in_idle = (r_state == S_IDLE);
  assign w_in_addr = (r_state == S_ADDR);
  assign w_in_data = (r_state == S_DATA);
  assign w_done    = w_in_data & HREADY;

  always_comb begin
    case (r_haddr[1:0])
      2'd0:    w_rbyte = HRDATA[7:0];
      2'd1:    w_rbyte = HRDATA[15:8];
      2'd2:    w_rbyte = HRDATA[23:16];
      default: w_rbyte = HRDATA[31:24];
    endcase
    w_rhalf = r_haddr[1] ? HRDATA[31:16] : HRDATA[15:0];
  end

  always_comb begin
    case (r_hsize)
      SZ_BYTE: w_load_ext = r_unsigned ? {24'd0, w_rbyte} : {{24{w_rbyte[7]}}, w_rbyte};
      SZ_HALF: w_load_ext = r_unsigned ? {16'd0, w_rhalf} : {{16{w_rhalf[15]}}, w_rhalf};
      default: w_load_ext = HRDATA;
    endcase
  end

  // The stall drops in the completion cycle so the pipeline advances on that edge.
  assign mem_stall  = rst_n & ((w_in_idle & w_go) | w_in_addr | (w_in_data & ~HREADY));
  assign rd_valid   = w_done & ~HRESP & ~r_hwrite;
  assign bus_error  = w_done & HRESP;
  assign addr_error = rst_n & w_in_idle & w_reject;
  assign ReadData_M = rd_valid ? w_load_ext : 32'd0;

  assign HADDR  = r_haddr;
  assign HTRANS = r_htrans;
  assign HWRITE = r_hwrite;
  assign HSIZE  = r_hsize;
  assign HWDATA = r_hwdata;
  assign HBURST = 3'b000;
  assign HPROT  = HPROT_VAL;

endmodule

`default_nettype wire
